// File: rtl/debounce_pkg.sv
// Shared types and defaults for switch/button input conditioning.
package debounce_pkg;

    localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'b00,
        CHECK_HIGH = 2'b01,
        IDLE_HIGH  = 2'b10,
        CHECK_LOW  = 2'b11
    } state_t;

    function automatic logic is_check(input state_t st);
        return (st == CHECK_HIGH) || (st == CHECK_LOW);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pins; 2-cycle latency, reset to 0.
// No flow control: samples every clock.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/debouncer.sv
// Debounces one switch: out follows in after STABLE_CYCLES unbroken samples, STABLE_CYCLES+2 edges total.
// No flow control: rise/fall are single-cycle pulses that must be consumed when seen.
module debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic s;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          busy_q;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (in),
        .q_o (s)
    );

    // Terminal count needs s at the new level, so abort and qualify are exclusive.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    out_d   = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_d = CHECK_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK_LOW: begin
                if (s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    out_d   = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= is_check(state_d);
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debouncer.sv
// Directed scenarios plus random bouncing, checked against a sample-history reference model.
module tb_debouncer;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in  = 1'b0;
    logic out, rise, fall, busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: delayed samples of in, and the recent history the filter looked at.
    bit dly[$];
    bit hist[$];
    bit m_out, m_rise, m_fall, m_busy;

    // Observation statistics for directed scenarios.
    int edge_no = 0;
    int rise_total, fall_total, busy_total, both_total;
    int last_rise_edge, last_fall_edge;

    debouncer #(
        .STABLE_CYCLES (N)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .out  (out),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        dly.delete();
        dly.push_back(1'b0);
        dly.push_back(1'b0);
        hist.delete();
        m_out  = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic clear_stats();
        rise_total     = 0;
        fall_total     = 0;
        busy_total     = 0;
        both_total     = 0;
        last_rise_edge = -1;
        last_fall_edge = -1;
    endtask

    task automatic check_outputs();
        chk("out",  out,  m_out);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("busy", busy, m_busy);
    endtask

    // One clock: drive inputs, advance model on the edge, compare 1 ns later.
    task automatic tick(input bit v, input bit r);
        bit samp, prev, flip;
        rst = r;
        in  = v;
        @(posedge clk);
        edge_no++;
        if (r) begin
            model_reset();
        end else begin
            samp = dly.pop_front();
            dly.push_back(v);
            hist.push_back(samp);
            if (hist.size() > N) void'(hist.pop_front());
            prev = m_out;
            flip = (hist.size() == N);
            foreach (hist[i]) if (hist[i] == m_out) flip = 1'b0;
            if (flip) m_out = !m_out;
            m_rise = m_out && !prev;
            m_fall = !m_out && prev;
            m_busy = (samp != m_out);
        end
        #1;
        check_outputs();
        if (rise) begin rise_total++; last_rise_edge = edge_no; end
        if (fall) begin fall_total++; last_fall_edge = edge_no; end
        if (busy) busy_total++;
        if (rise && fall) both_total++;
    endtask

    initial begin
        int e0;
        model_reset();
        clear_stats();
        #1;

        // 1: reset held with in=1, then a normal rise after release
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        clear_stats();
        e0 = edge_no + 1;
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
        chk("s1_rise_count", rise_total, 1);
        chk("s1_rise_latency", last_rise_edge - e0, N + 1);
        chk("s1_busy_cycles", busy_total, N - 1);
        chk("s1_out", out, 1);

        // 4: falling edge from out=1
        clear_stats();
        e0 = edge_no + 1;
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
        chk("s4_fall_count", fall_total, 1);
        chk("s4_fall_latency", last_fall_edge - e0, N + 1);
        chk("s4_rise_count", rise_total, 0);

        // 2: glitch of three cycles from idle low
        clear_stats();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
        chk("s2_rise_count", rise_total, 0);
        chk("s2_busy_cycles", busy_total, 3);
        chk("s2_state_idle_low", dut.state_q, debounce_pkg::IDLE_LOW);

        // 3: bounce 1,0,1,0,1 then steady 1
        clear_stats();
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        e0 = edge_no + 1;
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
        chk("s3_rise_count", rise_total, 1);
        chk("s3_fall_count", fall_total, 0);
        chk("s3_rise_latency", last_rise_edge - e0, N + 1);

        // 6: back-to-back rise then fall
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
        clear_stats();
        for (int i = 0; i < N + 2; i++) tick(1'b1, 1'b0);
        e0 = edge_no + 1;
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
        chk("s6_rise_count", rise_total, 1);
        chk("s6_fall_latency", last_fall_edge - e0, N + 1);
        chk("s6_no_overlap", both_total, 0);

        // 5: asynchronous reset while checking high with cnt=2
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        chk("s5_cnt_before", dut.cnt_q, 2);
        chk("s5_busy_before", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("s5_busy_async", busy, 0);
        chk("s5_out_async", out, 0);
        chk("s5_cnt_async", dut.cnt_q, 0);
        chk("s5_state_async", dut.state_q, debounce_pkg::IDLE_LOW);
        clear_stats();
        tick(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
        chk("s5_no_pulse", rise_total + fall_total, 0);

        // Random bouncing with occasional resets
        clear_stats();
        for (int seg = 0; seg < 80; seg++) begin
            bit v;
            bit r;
            int hold;
            v    = 1'($urandom_range(0, 1));
            r    = ($urandom_range(0, 39) == 0);
            hold = $urandom_range(1, 7);
            for (int k = 0; k < hold; k++) tick(v, r && (k == 0));
        end
        chk("rand_no_overlap", both_total, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debouncer.md
# debouncer

Input conditioner for one mechanical switch or button. Synchronises the raw asynchronous pin into `clk`, filters contact bounce by requiring the new level to hold for a programmable number of consecutive cycles, and presents a clean level plus one-cycle edge pulses. Sits directly upstream of the serial edge/transition detectors, driving their single-bit `in` with a glitch-free, clock-aligned signal.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronised samples at the new level required before `out` changes. Legal range ≥2. Board builds override it (e.g. 500000 at 50 MHz for 10 ms).
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `in`  input  1  raw switch level, asynchronous to `clk`, may bounce.
- `out`  output  1  debounced level (registered).
- `rise`  output  1  one-cycle pulse, high in the cycle `out` goes 0→1.
- `fall`  output  1  one-cycle pulse, high in the cycle `out` goes 1→0.
- `busy`  output  1  high while a candidate level change is being qualified.

## Operation
- Two-flop synchroniser: `in` → `s1` → `s`. Only `s` is used by the rest of the logic.
- Counter `cnt`, width `$clog2(STABLE_CYCLES)`, unsigned. It never exceeds `STABLE_CYCLES-1`, so there is no wrap.
- FSM has four states: `IDLE_LOW`, `CHECK_HIGH`, `IDLE_HIGH`, `CHECK_LOW`.
  - `IDLE_LOW`: if `s`=1, go to `CHECK_HIGH` and set `cnt`←1; else stay.
  - `CHECK_HIGH`:
    - `s`=0: back to `IDLE_LOW`, `cnt`←0, no pulse.
    - `s`=1 and `cnt`==`STABLE_CYCLES-1`: go to `IDLE_HIGH`, `out`←1, `rise`←1, `cnt`←0.
    - otherwise: `cnt`←`cnt`+1.
  - `IDLE_HIGH` and `CHECK_LOW`: mirror images of the above, with `fall` as the pulse.
- `busy` = state is `CHECK_HIGH` or `CHECK_LOW`. It is registered together with the state.
- `rise` and `fall` are registered, last exactly one cycle, and are never high together.
- Any single sample of `s` at the old level during a check aborts the check and restarts it from zero. Only an unbroken run of `STABLE_CYCLES` samples qualifies.
- A bounce that returns to the old level causes no output activity other than `busy`.

## Timing
- Reset values, applied immediately on `rst` assertion with no clock edge needed:
  - `s1`=0, `s`=0, `cnt`=0, state=`IDLE_LOW`;
  - `out`=0, `rise`=0, `fall`=0, `busy`=0.
- Reset mid-check discards the pending candidate.
- After reset release with `in` already 1, the block qualifies a normal rising transition.
- Latency: `in` changes and then holds, first captured by edge E0.
  - `s` changes after E1.
  - `busy` rises after E2.
  - `out`, and `rise` or `fall`, update after E(`STABLE_CYCLES`+1).
  - `busy` drops at that same edge.
- Minimum spacing between two qualified edges: `STABLE_CYCLES` cycles.
- Simultaneous events:
  - Reset overrides everything.
  - An abort sample and the terminal count cannot coincide, because the terminal count requires `s` at the new level.

## Structure
- Shared package `debounce_pkg` holds:
  - the state encoding (2-bit enum: `IDLE_LOW`=00, `CHECK_HIGH`=01, `IDLE_HIGH`=10, `CHECK_LOW`=11);
  - the default `STABLE_CYCLES` constant.
- One sub-module, `sync_2ff`: a two-flop synchroniser with asynchronous active-high reset to 0. It is reused by other pin inputs.
- The FSM, counter and output registers stay in `debouncer`.

## Test plan
All scenarios use `STABLE_CYCLES`=4.
1. Hold `rst`=1 with `in`=1 for 3 cycles, then release. All outputs read 0 during reset. After release, `out`=1 with a single `rise` pulse 5 edges after the first capturing edge, and `busy` is high for 3 cycles before that.
2. Glitch: from idle low, drive `in`=1 for 3 cycles, then 0. `out` stays 0, `rise` never asserts, `busy` pulses, and the FSM returns to `IDLE_LOW`.
3. Bounce: `in` toggles 1,0,1,0,1 at one cycle each, then stays 1. Exactly one `rise`, arriving 5 edges after the final 0→1 capture. `out` never toggles before that.
4. Falling edge: from `out`=1, drive `in`=0 steady. Exactly one `fall` pulse and `out`=0 after 5 edges. `rise` stays 0 throughout.
5. Asynchronous reset: assert `rst` between clock edges while in `CHECK_HIGH` with `cnt`=2. `busy`, `out` and `cnt` clear before the next edge. After release with `in`=0, no pulse occurs.
6. Back-to-back: a qualified rise followed immediately by `in`=0. The `fall` pulse comes exactly 5 edges after the 0 is captured, and `rise` and `fall` are never high in the same cycle.
